// File: rtl/shot_pool.sv
// Pool of N_SHOTS projectile slots: spawn on fire release into the lowest free slot,
// move upward on a divided tick, retire past Y_LIMIT or on collision hit_clear.
module shot_pool #(
  parameter int N_SHOTS  = 8,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int SPAWN_Y  = 424,
  parameter int Y_LIMIT  = -10,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 60000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               fire,
  input  logic [XW-1:0]                      pos_x,
  input  logic [N_SHOTS-1:0]                 hit_clear,
  output logic [N_SHOTS-1:0]                 shot_valid,
  output logic [N_SHOTS*XW-1:0]              shot_x,
  output logic signed [N_SHOTS*YW-1:0]       shot_y,
  output logic [$clog2(N_SHOTS+1)-1:0]       active_count,
  output logic                               pool_full,
  output logic                               fire_drop
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ACW = $clog2(N_SHOTS+1);
  localparam logic [CW-1:0]        TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [YW-1:0] SPAWN_V   = YW'(SPAWN_Y);
  localparam logic signed [YW-1:0] Y_LIM_V   = YW'(Y_LIMIT);
  localparam logic signed [YW-1:0] STEP_V    = YW'(STEP);

  logic [CW-1:0]        tick_cnt;
  logic                 fire_q;
  logic                 spawn_req;
  logic                 move_tick;
  logic                 found;
  logic [N_SHOTS-1:0]   alloc;
  logic [XW-1:0]        x_r [N_SHOTS];
  logic signed [YW-1:0] y_r [N_SHOTS];

  assign spawn_req = fire_q & ~fire;
  assign move_tick = (tick_cnt == TICK_LAST);

  // Lowest-index slot free at the start of the cycle; slots cleared this cycle stay ineligible.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SHOTS; i++) begin
      if (!found && !shot_valid[i]) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      fire_q     <= 1'b0;
      fire_drop  <= 1'b0;
      shot_valid <= '0;
      for (int unsigned i = 0; i < N_SHOTS; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
    end else begin
      tick_cnt  <= move_tick ? '0 : tick_cnt + 1'b1;
      fire_q    <= fire;
      fire_drop <= spawn_req & pool_full;
      for (int unsigned i = 0; i < N_SHOTS; i++) begin
        if (shot_valid[i]) begin
          if (hit_clear[i]) begin
            shot_valid[i] <= 1'b0;
          end else if (move_tick) begin
            if (y_r[i] >= Y_LIM_V) y_r[i] <= y_r[i] - STEP_V;
            else                   shot_valid[i] <= 1'b0;
          end
        end else if (spawn_req && alloc[i]) begin
          shot_valid[i] <= 1'b1;
          x_r[i]        <= pos_x;
          y_r[i]        <= SPAWN_V;
        end
      end
    end
  end

  always_comb begin
    shot_x       = '0;
    shot_y       = '0;
    active_count = '0;
    for (int unsigned i = 0; i < N_SHOTS; i++) begin
      shot_x[i*XW +: XW] = x_r[i];
      shot_y[i*YW +: YW] = y_r[i];
      active_count       = active_count + ACW'(shot_valid[i]);
    end
  end

  assign pool_full = &shot_valid;

endmodule
